// File: rtl/parity_frame_pkg.sv
// Shared types and helpers for the parity frame checker: FSM state encoding and
// the saturating-increment function used by the frame and error counters.
package parity_frame_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        CHECK  = 2'd1,
        REPORT = 2'd2
    } state_e;

    // Counters up to this width share one increment helper.
    localparam int unsigned SatW = 32;

    function automatic logic [SatW-1:0] sat_inc(input logic [SatW-1:0] val,
                                                 input logic [SatW-1:0] max_val,
                                                 input logic            inc);
        if (inc && (val != max_val)) begin
            return val + 32'd1;
        end
        return val;
    endfunction

endpackage

// File: rtl/parity_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; holds at all-ones.
module parity_sat_counter
    import parity_frame_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [SatW-1:0] MaxVal = SatW'({CNT_W{1'b1}});

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign count_d = CNT_W'(sat_inc(SatW'(count_q), MaxVal, inc));
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/parity_frame_checker.sv
// XOR-accumulates FRAME_LEN word parities, compares against a trailing check bit and
// reports the result over a valid/ready handshake. Optional abort: PARITY_FRAME_ABORT_EN.
module parity_frame_checker
    import parity_frame_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    output logic             res_valid,
    input  logic             res_ready,
`ifdef PARITY_FRAME_ABORT_EN
    input  logic             abort,
`endif
    output logic             res_parity,
    output logic             res_error,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned IdxW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_LEN - 1);

    state_e          state_q, state_d;
    logic            acc_q, acc_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            res_parity_q, res_parity_d;
    logic            res_error_q, res_error_d;
    logic            accept;
    logic            abort_hit;
    logic            frame_inc;
    logic            err_inc;

    assign in_ready   = (state_q != REPORT);
    assign accept     = in_valid & in_ready;
    assign res_valid  = (state_q == REPORT);
    assign res_parity = res_parity_q;
    assign res_error  = res_error_q;

`ifdef PARITY_FRAME_ABORT_EN
    assign abort_hit = abort & (state_q != REPORT);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        res_parity_d = res_parity_q;
        res_error_d  = res_error_q;
        frame_inc    = 1'b0;
        err_inc      = 1'b0;

        // Abort wins over a same-cycle accept; the accepted bit is simply dropped.
        if (abort_hit) begin
            state_d = ACCUM;
            acc_d   = 1'b0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_d = acc_q ^ in_bit;
                        if (idx_q == LastIdx) begin
                            idx_d   = '0;
                            state_d = CHECK;
                        end else begin
                            idx_d = idx_q + IdxW'(1);
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        res_parity_d = acc_q;
                        res_error_d  = acc_q ^ in_bit;
                        frame_inc    = 1'b1;
                        err_inc      = acc_q ^ in_bit;
                        state_d      = REPORT;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        acc_d   = 1'b0;
                        idx_d   = '0;
                        state_d = ACCUM;
                    end
                end
                default: begin
                    acc_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            acc_q        <= 1'b0;
            idx_q        <= '0;
            res_parity_q <= 1'b0;
            res_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            res_parity_q <= res_parity_d;
            res_error_q  <= res_error_d;
        end
    end

    parity_sat_counter #(
        .CNT_W (CNT_W)
    ) u_frame_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (frame_inc),
        .count (frame_count)
    );

    parity_sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .count (err_count)
    );

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker: FRAME_LEN=8/CNT_W=8 main instance plus a
// FRAME_LEN=1/CNT_W=2 instance for saturation. Abort steps need PARITY_FRAME_ABORT_EN.
module tb_parity_frame_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       res_ready = 1'b0;
    logic       in_ready;
    logic       res_valid;
    logic       res_parity;
    logic       res_error;
    logic [7:0] frame_count;
    logic [7:0] err_count;
`ifdef PARITY_FRAME_ABORT_EN
    logic       abort = 1'b0;
    logic       abort2 = 1'b0;
`endif

    logic       in2_valid = 1'b0;
    logic       in2_bit = 1'b0;
    logic       res2_ready = 1'b0;
    logic       in2_ready;
    logic       res2_valid;
    logic       res2_parity;
    logic       res2_error;
    logic [1:0] frame2_count;
    logic [1:0] err2_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    parity_frame_checker #(
        .FRAME_LEN (8),
        .CNT_W     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bit      (in_bit),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
`ifdef PARITY_FRAME_ABORT_EN
        .abort       (abort),
`endif
        .res_parity  (res_parity),
        .res_error   (res_error),
        .frame_count (frame_count),
        .err_count   (err_count)
    );

    parity_frame_checker #(
        .FRAME_LEN (1),
        .CNT_W     (2)
    ) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in2_valid),
        .in_ready    (in2_ready),
        .in_bit      (in2_bit),
        .res_valid   (res2_valid),
        .res_ready   (res2_ready),
`ifdef PARITY_FRAME_ABORT_EN
        .abort       (abort2),
`endif
        .res_parity  (res2_parity),
        .res_error   (res2_error),
        .frame_count (frame2_count),
        .err_count   (err2_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one bit and returns #1 after the edge that accepts it.
    task automatic send_bit(input logic b);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word_bits(input logic [7:0] bits);
        for (int i = 7; i >= 0; i--) send_bit(bits[i]);
    endtask

    task automatic take_result(input string tag, input logic ep, input logic ee);
        chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        chk({tag, "_parity"}, {31'd0, res_parity}, {31'd0, ep});
        chk({tag, "_error"}, {31'd0, res_error}, {31'd0, ee});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_released"}, {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        logic       model_acc;
        logic       chkbit;
        int         err_model;

        // Reset state
        tick();
        tick();
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();
        chk("rst_res_parity", {31'd0, res_parity}, 32'd0);
        chk("rst_res_error", {31'd0, res_error}, 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);

        // Frame 1: 1,0,1,1,0,0,1,0 has even parity; check bit 0 matches
        send_word_bits(8'b1011_0010);
        chk("f1_not_yet_valid", {31'd0, res_valid}, 32'd0);
        chk("f1_ready_in_check", {31'd0, in_ready}, 32'd1);
        send_bit(1'b0);
        chk("f1_frame_count", 32'(frame_count), 32'd1);
        chk("f1_err_count", 32'(err_count), 32'd0);
        take_result("f1", 1'b0, 1'b0);

        // Frame 2: same bits, check bit 1 mismatches; result held for 5 cycles
        send_word_bits(8'b1011_0010);
        send_bit(1'b1);
        chk("f2_frame_count", 32'(frame_count), 32'd2);
        chk("f2_err_count", 32'(err_count), 32'd1);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_parity", {31'd0, res_parity}, 32'd0);
            chk("hold_error", {31'd0, res_error}, 32'd1);
            chk("hold_frame_count", 32'(frame_count), 32'd2);
        end
        in_valid = 1'b0;
        take_result("f2", 1'b0, 1'b1);

        // Asynchronous reset mid-frame at idx=4 (acc=1)
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_frame_count", 32'(frame_count), 32'd0);
        chk("rst_mid_err_count", 32'(err_count), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();

        // Full frame after reset, then reset again while in REPORT
        send_word_bits(8'b1000_0000);
        send_bit(1'b0);
        chk("r1_valid", {31'd0, res_valid}, 32'd1);
        chk("r1_parity", {31'd0, res_parity}, 32'd1);
        chk("r1_error", {31'd0, res_error}, 32'd1);
        chk("r1_frame_count", 32'(frame_count), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_rep_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_rep_parity", {31'd0, res_parity}, 32'd0);
        chk("rst_rep_error", {31'd0, res_error}, 32'd0);
        chk("rst_rep_frame_count", 32'(frame_count), 32'd0);
        chk("rst_rep_err_count", 32'(err_count), 32'd0);
        chk("rst_rep_in_ready", {31'd0, in_ready}, 32'd1);
        #2;
        rst_n = 1'b1;
        tick();

        // 100 frames with random input gaps against an XOR model
        err_model = 0;
        for (int f = 0; f < 100; f++) begin
            model_acc = 1'b0;
            for (int i = 0; i < 8; i++) begin
                logic b;
                b = 1'($urandom_range(1));
                model_acc = model_acc ^ b;
                if ($urandom_range(1) == 1) tick();
                send_bit(b);
            end
            chkbit = 1'($urandom_range(1));
            if ($urandom_range(1) == 1) tick();
            send_bit(chkbit);
            if (model_acc != chkbit) err_model++;
            take_result("rnd", model_acc, model_acc ^ chkbit);
        end
        chk("rnd_frame_count", 32'(frame_count), 32'd100);
        chk("rnd_err_count", 32'(err_count), 32'(err_model));

`ifdef PARITY_FRAME_ABORT_EN
        // Abort at idx=3 together with a valid bit; following frame must be clean
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        #1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_no_result", {31'd0, res_valid}, 32'd0);
        chk("abort_frame_count", 32'(frame_count), 32'd100);
        chk("abort_err_count", 32'(err_count), 32'(err_model));
        send_word_bits(8'b1011_0010);
        send_bit(1'b1);
        chk("post_abort_frame_count", 32'(frame_count), 32'd101);
        chk("post_abort_err_count", 32'(err_count), 32'(err_model + 1));
        take_result("post_abort", 1'b0, 1'b1);
`endif

        // FRAME_LEN=1, CNT_W=2: five mismatching frames saturate both counters at 3
        for (int f = 0; f < 5; f++) begin
            in2_valid = 1'b1;
            in2_bit   = 1'b1;
            tick();
            chk("fl1_in_check_ready", {31'd0, in2_ready}, 32'd1);
            chk("fl1_in_check_valid", {31'd0, res2_valid}, 32'd0);
            in2_bit = 1'b0;
            tick();
            in2_valid = 1'b0;
            chk("fl1_valid", {31'd0, res2_valid}, 32'd1);
            chk("fl1_parity", {31'd0, res2_parity}, 32'd1);
            chk("fl1_error", {31'd0, res2_error}, 32'd1);
            chk("sat_frame_count", 32'(frame2_count), (f < 3) ? 32'(f + 1) : 32'd3);
            chk("sat_err_count", 32'(err2_count), (f < 3) ? 32'(f + 1) : 32'd3);
            res2_ready = 1'b1;
            tick();
            res2_ready = 1'b0;
        end
        chk("sat_err_final", 32'(err2_count), 32'd3);
        chk("sat_frame_final", 32'(frame2_count), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Sequential stage directly downstream of the 16-input combinational parity tree (16 data bits in, one parity bit out).
- Consumes one parity bit per 16-bit word over a valid/ready stream and XOR-accumulates FRAME_LEN word parities into a frame parity.
- Compares the frame parity against a trailing check bit and reports match/mismatch through a result handshake.
- Keeps saturating frame and error counters for the benchmark harness.

Parameters:
- FRAME_LEN, 8, number of word-parity bits per frame (must be >= 1).
- CNT_W, 8, width of frame_count and err_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_bit is valid.
- in_ready  out  1  block accepts in_bit this cycle.
- in_bit  in  1  word parity (po0 of the parity tree) or frame check bit.
- res_valid  out  1  frame result available.
- res_ready  in  1  downstream consumes the result.
- res_parity  out  1  accumulated frame parity (XOR of FRAME_LEN word bits).
- res_error  out  1  1 when res_parity != check bit.
- frame_count  out  CNT_W  frames completed, saturating.
- err_count  out  CNT_W  frames with res_error=1, saturating.
- abort  in  1  present only with PARITY_FRAME_ABORT_EN.

Behaviour:
- Accept: in_valid & in_ready. in_ready = (state != REPORT), combinational from state only.
- States:
  - ACCUM: index idx 0..FRAME_LEN-1, acc ^= in_bit on each accept. On the accept at idx = FRAME_LEN-1, go to CHECK.
  - CHECK: the next accepted bit is the check bit. Register res_parity = acc and res_error = acc ^ in_bit, then go to REPORT.
  - REPORT: res_valid = 1, in_ready = 0. When res_ready = 1: clear acc and idx, return to ACCUM.
- Latency: res_valid is asserted the cycle after the check bit is accepted.
- Result hold: res_parity and res_error stay stable while res_valid & !res_ready.
- Input gaps: in_valid = 0 at any point stalls with no state change.
- Counters:
  - frame_count and err_count update in the same cycle the check bit is accepted.
  - err_count increments only when the mismatch is 1.
  - Both saturate at 2^CNT_W-1; no wrap.
- Back-to-back frames: the first word of the next frame can be accepted at the earliest one cycle after the result handshake, since in_ready = 0 during REPORT.
- Widths: idx is $clog2(FRAME_LEN) bits, minimum 1 bit.
- FRAME_LEN = 1: ACCUM lasts exactly one accept.
- Reset (asynchronous, any state, including mid-frame or mid-REPORT):
  - state = ACCUM; acc = 0; idx = 0.
  - res_valid = 0; res_parity = 0; res_error = 0.
  - frame_count = 0; err_count = 0.
  - in_ready = 1 after reset deasserts.

Optional Feature:
PARITY_FRAME_ABORT_EN
- Defined:
  - abort port exists. abort = 1 in ACCUM or CHECK clears acc and idx, returns to ACCUM, updates no counters and produces no result.
  - Abort has priority over a simultaneous accept; that input bit is dropped, but the handshake still completes, so in_ready stays 1.
  - abort is ignored in REPORT.
- Undefined: no abort port; frames only end via the check bit.

Decomposition:
- Package parity_frame_pkg holds:
  - state enum typedef {ACCUM, CHECK, REPORT};
  - sat_inc function for the saturating counters.
- One sub-module, parity_sat_counter (CNT_W, inc, async active-low reset), instantiated twice for frame_count and err_count.

Test Plan:
- FRAME_LEN=8, bits 1,0,1,1,0,0,1,0 then check 0 -> res_parity=0, res_error=0, res_valid the next cycle, frame_count=1, err_count=0.
- Same bits with check 1 -> res_error=1, err_count=1; res_ready held 0 for 5 cycles -> outputs stable, in_ready=0 throughout.
- Random in_valid gaps (50% duty) over 100 frames vs. reference XOR model -> all results match; frame_count=100.
- CNT_W=2, 5 error frames -> err_count saturates at 3, frame_count=3.
- rst_n pulsed low at idx=4 and again during REPORT -> all outputs 0 immediately; the next full frame is checked correctly.
- With PARITY_FRAME_ABORT_EN: abort at idx=3 together with a valid bit -> bit dropped, no result; the following frame is correct, counters unchanged by the aborted frame.
